// File: rtl/fetch_queue_if.sv
// Fetch-to-IF/ID bundle bus: fetch-side push handshake, IF/ID-side register inputs, control.
// master = fetch/control side, slave = fetch_queue.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [63:0]   pc_in;
  logic [63:0]   inst_in;
  logic [63:0]   recv_pc_in;
  logic [3:0]    pred_result_in;
  logic          flush;
  logic          stall;
  logic          out_valid;
  logic [63:0]   pc_if_id_in;
  logic [63:0]   inst_if_id_in;
  logic [63:0]   recv_pc_if_id_in;
  logic [3:0]    pred_result_if_id_in;
  logic [CW-1:0] count;

  modport master (
    output in_valid, pc_in, inst_in, recv_pc_in, pred_result_in, flush, stall,
    input  in_ready, out_valid, pc_if_id_in, inst_if_id_in, recv_pc_if_id_in,
           pred_result_if_id_in, count
  );

  modport slave (
    input  in_valid, pc_in, inst_in, recv_pc_in, pred_result_in, flush, stall,
    output in_ready, out_valid, pc_if_id_in, inst_if_id_in, recv_pc_if_id_in,
           pred_result_if_id_in, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue feeding the IF/ID register; head entry is read combinationally.
// Define FETCH_QUEUE_BYPASS_EN to forward an incoming bundle straight to IF/ID when empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] recv_pc;
    logic [3:0]  pred;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic   empty;
  logic   full;
  logic   bypass;
  logic   push;
  logic   pop;
  logic   wr_en;
  logic   rd_en;
  entry_t in_entry;
  entry_t out_entry;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_entry = {bus.pc_in, bus.inst_in, bus.recv_pc_in, bus.pred_result_in};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & bus.in_valid & ~bus.flush;
`else
  assign bypass = 1'b0;
`endif

  assign bus.in_ready  = ~full & ~bus.flush;
  assign bus.out_valid = ~empty | bypass;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & ~bus.stall & ~bus.flush;
  // A bypassed bundle taken by IF/ID this cycle never touches storage.
  assign wr_en         = push & ~(bypass & ~bus.stall);
  assign rd_en         = pop & ~empty;

  always_comb begin
    out_entry = '{pc: '0, inst: {4{NOP_INST}}, recv_pc: '0, pred: '0};
    if (!empty) begin
      out_entry = mem[rd_ptr];
    end else if (bypass) begin
      out_entry = in_entry;
    end
  end

  assign bus.pc_if_id_in          = out_entry.pc;
  assign bus.inst_if_id_in        = out_entry.inst;
  assign bus.recv_pc_if_id_in     = out_entry.recv_pc;
  assign bus.pred_result_if_id_in = out_entry.pred;
  assign bus.count                = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      cnt    <= cnt + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end
endmodule
